// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file types and core-default sizes
package regfile_pkg;
  localparam int DEF_NUM_REG = 32;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REG);
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ZERO_REG_ADDR = 0;
  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
  typedef struct packed {
    logic valid;
    reg_addr_t addr;
    reg_data_t data;
  } regfile_wr_t;
endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: same-address write conflict resolution, lower port index wins
module regfile_wr_arbiter #(
  parameter int NUM_WR_PORTS = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                               rst,
  input  logic [NUM_WR_PORTS-1:0]            wr_valid,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_WR_PORTS-1:0]            wr_ready,
  output logic [NUM_WR_PORTS-1:0]            wr_acc
);
  for (genvar i = 0; i < NUM_WR_PORTS; i++) begin : g_port
    logic conflict;
    always_comb begin
      conflict = 1'b0;
      for (int j = 0; j < i; j++)
        conflict = conflict | (wr_valid[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    assign wr_ready[i] = !rst && !conflict;
    assign wr_acc[i] = wr_valid[i] && wr_ready[i];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: flop register file with busy scoreboard, write arbitration and bypass
module regfile_scoreboard #(
  parameter int NUM_REG = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REG),
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_out,
  output logic [NUM_RD_PORTS-1:0]            rd_busy_out,
  input  logic                               rsv_valid_in,
  input  logic [ADDR_WIDTH-1:0]              rsv_addr_in,
  output logic                               rsv_ready_out,
  input  logic [NUM_WR_PORTS-1:0]            wr_valid_in,
  input  logic [NUM_WR_PORTS*ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_in,
  output logic [NUM_WR_PORTS-1:0]            wr_ready_out
);
  import regfile_pkg::*;
  logic [DATA_WIDTH-1:0]   regs_ff [NUM_REG];
  logic [NUM_REG-1:0]      busy_ff;
  logic [NUM_WR_PORTS-1:0] wr_acc;
  logic [NUM_REG-1:0]      wr_hit;
  logic [DATA_WIDTH-1:0]   wr_hit_data [NUM_REG];
  logic                    rsv_zero;
  logic                    rsv_acc;
  regfile_wr_arbiter #(
    .NUM_WR_PORTS(NUM_WR_PORTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_arb (
    .rst(rst),
    .wr_valid(wr_valid_in),
    .wr_addr(wr_addr_in),
    .wr_ready(wr_ready_out),
    .wr_acc(wr_acc)
  );
  // Arbitration guarantees at most one accepted write per address, so the per-register view is unambiguous
  always_comb begin
    wr_hit = '0;
    for (int a = 0; a < NUM_REG; a++) begin
      wr_hit_data[a] = '0;
      for (int p = 0; p < NUM_WR_PORTS; p++)
        if (wr_acc[p] && wr_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a)) begin
          wr_hit[a] = 1'b1;
          wr_hit_data[a] = wr_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end
  end
  assign rsv_zero = ZERO_REG != 0 && rsv_addr_in == ADDR_WIDTH'(ZERO_REG_ADDR);
  assign rsv_ready_out = !rst && (rsv_zero || !busy_ff[rsv_addr_in] || wr_hit[rsv_addr_in]);
  assign rsv_acc = rsv_valid_in && rsv_ready_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_ff <= '0;
      for (int a = 0; a < NUM_REG; a++) regs_ff[a] <= '0;
    end else begin
      for (int a = 0; a < NUM_REG; a++) begin
        if (wr_hit[a] && !(ZERO_REG != 0 && a == ZERO_REG_ADDR)) regs_ff[a] <= wr_hit_data[a];
        if (rsv_acc && !rsv_zero && rsv_addr_in == ADDR_WIDTH'(a)) busy_ff[a] <= 1'b1;
        else if (wr_hit[a]) busy_ff[a] <= 1'b0;
      end
    end
  end
  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic zero, fwd;
    assign addr = rd_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero = ZERO_REG != 0 && addr == ADDR_WIDTH'(ZERO_REG_ADDR);
    assign fwd = BYPASS != 0 && wr_hit[addr];
    assign rd_data_out[k*DATA_WIDTH +: DATA_WIDTH] = zero ? '0 : fwd ? wr_hit_data[addr] : regs_ff[addr];
    // A same-cycle reservation keeps the register busy even while its old writeback is forwarded
    assign rd_busy_out[k] = !zero && busy_ff[addr] && !(fwd && !(rsv_acc && rsv_addr_in == addr));
  end
endmodule
